// File: rtl/mvm_pkg.sv
`default_nettype none
// mvm_pkg: FSM state type and fixed-point helpers shared by the MVM engine.
// Revision: 1.0
package mvm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_NORM = 2'd2
  } state_t;

  function automatic int acc_w(input int num_bit, input int num_vector);
    return 2 * num_bit + $clog2(num_vector + 1) + 1;
  endfunction

  // Round half up with an arithmetic shift, then clamp to the signed num_bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac_bit,
                                                   input int num_bit);
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rounded = (frac_bit > 0) ? ((acc + (64'sd1 <<< (frac_bit - 1))) >>> frac_bit) : acc;
    max_v   = (64'sd1 <<< (num_bit - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (num_bit - 1));
    if (rounded > max_v) return max_v;
    if (rounded < min_v) return min_v;
    return rounded;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_mac_lane.sv
`default_nettype none
// mvm_mac_lane: one output row -- LANES signed multipliers, adder and a loadable accumulator.
// Revision: 1.0
module mvm_mac_lane #(
  parameter int NUM_BIT = 8,
  parameter int LANES   = 1,
  parameter int ACC_W   = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic                             en,
  input  logic signed [ACC_W-1:0]          load_val,
  input  logic [LANES-1:0][NUM_BIT-1:0]    x,
  input  logic [LANES-1:0][NUM_BIT-1:0]    w,
  output logic signed [ACC_W-1:0]          acc
);

  localparam int PW = 2 * NUM_BIT;

  logic signed [PW-1:0]    prod [LANES];
  logic signed [ACC_W-1:0] sum;

  for (genvar l = 0; l < LANES; l++) begin : g_mul
    assign prod[l] = $signed(x[l]) * $signed(w[l]);
  end

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = sum + {{(ACC_W - PW){prod[l][PW-1]}}, prod[l]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (en) begin
      acc <= acc + sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mvm_engine.sv
`default_nettype none
// mvm_engine: signed fixed-point matrix-vector engine, y[i] = sum_j x[j][i]*w[j], LANES columns per cycle.
// Revision: 1.0
module mvm_engine
  import mvm_pkg::*;
#(
  parameter int NUM_BIT    = 8,
  parameter int FRAC_BIT   = 7,
  parameter int DIM        = 4,
  parameter int NUM_VECTOR = 4,
  parameter int LANES      = 1
) (
  input  logic                                        i_clk_mvmEngine,
  input  logic                                        i_rst_mvmEngine,
  input  logic                                        i_start_mvmEngine,
  input  logic                                        i_accum,
  input  logic [NUM_VECTOR-1:0][DIM-1:0][NUM_BIT-1:0] i_x_vectors,
  input  logic [NUM_VECTOR-1:0][NUM_BIT-1:0]          i_wts,
  output logic [DIM-1:0][NUM_BIT-1:0]                 o_y_vector,
  output logic                                        o_busy,
  output logic                                        o_done
);

  localparam int ACC_W = acc_w(NUM_BIT, NUM_VECTOR);
  localparam int ITER  = (NUM_VECTOR + LANES - 1) / LANES;
  localparam int KW    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);

  state_t                                      state;
  logic [KW-1:0]                               k;
  logic [NUM_VECTOR-1:0][DIM-1:0][NUM_BIT-1:0] x_q;
  logic [NUM_VECTOR-1:0][NUM_BIT-1:0]          w_q;
  logic                                        start_ok;
  logic                                        mac_en;
  logic signed [ACC_W-1:0]                     acc     [DIM];
  logic signed [ACC_W-1:0]                     preload [DIM];
  logic [DIM-1:0][LANES-1:0][NUM_BIT-1:0]      lane_x;
  logic [LANES-1:0][NUM_BIT-1:0]               lane_w;
  logic [DIM-1:0][NUM_BIT-1:0]                 y_next;

  assign start_ok = (state == ST_IDLE) && i_start_mvmEngine;
  assign mac_en   = (state == ST_MAC);

  // Columns past NUM_VECTOR (last partial group) stay zero and add nothing.
  always_comb begin
    lane_x = '0;
    lane_w = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < NUM_VECTOR; j++) begin
        if (int'(k) * LANES + l == j) begin
          lane_w[l] = w_q[j];
          for (int i = 0; i < DIM; i++) begin
            lane_x[i][l] = x_q[j][i];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      preload[i] = i_accum ?
                   ({{(ACC_W - NUM_BIT){o_y_vector[i][NUM_BIT-1]}}, o_y_vector[i]} <<< FRAC_BIT) : '0;
      y_next[i]  = NUM_BIT'(round_sat({{(64 - ACC_W){acc[i][ACC_W-1]}}, acc[i]}, FRAC_BIT, NUM_BIT));
    end
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    mvm_mac_lane #(
      .NUM_BIT (NUM_BIT),
      .LANES   (LANES),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk      (i_clk_mvmEngine),
      .rst      (i_rst_mvmEngine),
      .load     (start_ok),
      .en       (mac_en),
      .load_val (preload[i]),
      .x        (lane_x[i]),
      .w        (lane_w),
      .acc      (acc[i])
    );
  end

  always_ff @(posedge i_clk_mvmEngine) begin
    if (i_rst_mvmEngine) begin
      state      <= ST_IDLE;
      k          <= '0;
      x_q        <= '0;
      w_q        <= '0;
      o_y_vector <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start_mvmEngine) begin
            x_q    <= i_x_vectors;
            w_q    <= i_wts;
            k      <= '0;
            o_busy <= 1'b1;
            state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          k <= k + 1'b1;
          if (k == K_LAST) state <= ST_NORM;
        end
        ST_NORM: begin
          o_y_vector <= y_next;
          o_done     <= 1'b1;
          o_busy     <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mvm_engine.sv
`default_nettype none
// tb_mvm_engine: scoreboard bench for the default engine and a LANES=2, NUM_VECTOR=5, DIM=3 build.
// Revision: 1.0
module tb_mvm_engine;

  typedef struct {
    logic [31:0] y;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];

  logic                  start_a = 1'b0, accum_a = 1'b0;
  logic [3:0][3:0][7:0]  xa = '0;
  logic [3:0][7:0]       wa = '0;
  logic [3:0][7:0]       ya;
  logic                  busy_a, done_a;

  logic                  start_b = 1'b0, accum_b = 1'b0;
  logic [4:0][2:0][7:0]  xb = '0;
  logic [4:0][7:0]       wb = '0;
  logic [2:0][7:0]       yb;
  logic                  busy_b, done_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mvm_engine u_dut_a (
    .i_clk_mvmEngine   (clk),
    .i_rst_mvmEngine   (rst),
    .i_start_mvmEngine (start_a),
    .i_accum           (accum_a),
    .i_x_vectors       (xa),
    .i_wts             (wa),
    .o_y_vector        (ya),
    .o_busy            (busy_a),
    .o_done            (done_a)
  );

  mvm_engine #(.NUM_BIT(8), .FRAC_BIT(7), .DIM(3), .NUM_VECTOR(5), .LANES(2)) u_dut_b (
    .i_clk_mvmEngine   (clk),
    .i_rst_mvmEngine   (rst),
    .i_start_mvmEngine (start_b),
    .i_accum           (accum_b),
    .i_x_vectors       (xb),
    .i_wts             (wb),
    .o_y_vector        (yb),
    .o_busy            (busy_b),
    .o_done            (done_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vecs++;
    if (got !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && done_a) begin
      vecs++;
      if (exp_a.size() == 0) begin
        errs++;
        $display("FAIL a_unexpected_done: got done with y=%h, required no done", ya);
      end else begin
        e = exp_a.pop_front();
        if (ya !== e.y || cyc != e.cyc || busy_a !== 1'b0) begin
          errs++;
          $display("FAIL a_result: got y=%h cyc=%0d busy=%b, required y=%h cyc=%0d busy=0",
                   ya, cyc, busy_a, e.y, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && done_b) begin
      vecs++;
      if (exp_b.size() == 0) begin
        errs++;
        $display("FAIL b_unexpected_done: got done with y=%h, required no done", yb);
      end else begin
        e = exp_b.pop_front();
        if ({8'h00, yb} !== e.y || cyc != e.cyc || busy_b !== 1'b0) begin
          errs++;
          $display("FAIL b_result: got y=%h cyc=%0d busy=%b, required y=%h cyc=%0d busy=0",
                   yb, cyc, busy_b, e.y, e.cyc);
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge, then inputs are scrambled.
  task automatic issue_a(input logic [7:0] xv, input logic [7:0] wv, input logic acc,
                         input logic [7:0] yv, input logic expect_done);
    for (int j = 0; j < 4; j++) begin
      wa[j] = wv;
      for (int i = 0; i < 4; i++) xa[j][i] = xv;
    end
    accum_a = acc;
    start_a = 1'b1;
    if (expect_done) exp_a.push_back('{y: {4{yv}}, cyc: cyc + 6});
    @(negedge clk);
    start_a = 1'b0;
    accum_a = 1'b0;
    xa      = {16{8'h5A}};
    wa      = {4{8'hA5}};
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) begin
      vecs++;
      errs++;
      $display("FAIL a_timeout: got no done in 20 cycles, required done");
    end
  endtask

  task automatic issue_b(input logic [4:0][2:0][7:0] x, input logic [4:0][7:0] w, input logic [23:0] yv);
    xb      = x;
    wb      = w;
    start_b = 1'b1;
    exp_b.push_back('{y: {8'h00, yv}, cyc: cyc + 5});
    @(negedge clk);
    start_b = 1'b0;
    xb      = '1;
    wb      = '1;
  endtask

  task automatic wait_done_b();
    int n = 0;
    while (!done_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done_b) begin
      vecs++;
      errs++;
      $display("FAIL b_timeout: got no done in 20 cycles, required done");
    end
  endtask

  // Reference: exact products, round half up, saturate to 8 bits.
  function automatic logic [23:0] model_b(input logic [4:0][2:0][7:0] x, input logic [4:0][7:0] w);
    logic [23:0] r;
    longint      s;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      s = 0;
      for (int j = 0; j < 5; j++) s += longint'($signed(x[j][i])) * longint'($signed(w[j]));
      s = (s + 64) >>> 7;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      r[i*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [4:0][2:0][7:0] bx;
    logic [4:0][7:0]      bw;

    repeat (3) @(negedge clk);
    check("reset_y_a", ya, 32'h0);
    check("reset_busy_a", {31'b0, busy_a}, 32'h0);
    check("reset_done_a", {31'b0, done_a}, 32'h0);
    check("reset_y_b", {8'h00, yb}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue_a(8'd32, 8'd64, 1'b0, 8'd64, 1'b1);
    check("busy_in_mac", {31'b0, busy_a}, 32'h1);
    wait_done_a(); @(negedge clk);
    issue_a(8'hC0, 8'hC0, 1'b0, 8'h7F, 1'b1); wait_done_a(); @(negedge clk);
    issue_a(8'h80, 8'h7F, 1'b0, 8'h80, 1'b1); wait_done_a(); @(negedge clk);
    issue_a(8'h01, 8'd16, 1'b0, 8'h01, 1'b1); wait_done_a(); @(negedge clk);
    issue_a(8'hFF, 8'd16, 1'b0, 8'h00, 1'b1); wait_done_a(); @(negedge clk);
    issue_a(8'h01, 8'd32, 1'b0, 8'h01, 1'b1); wait_done_a(); @(negedge clk);

    // Accumulation chain, each job started in the previous job's done cycle.
    issue_a(8'd32, 8'd64, 1'b0, 8'd64, 1'b1); wait_done_a();
    issue_a(8'd32, 8'd64, 1'b1, 8'h7F, 1'b1); wait_done_a();
    issue_a(8'd32, 8'hC0, 1'b1, 8'd63, 1'b1); wait_done_a(); @(negedge clk);

    // Start pulsed mid-job must be dropped: exactly one done, carrying the first job's result.
    issue_a(8'd32, 8'd64, 1'b0, 8'd64, 1'b1);
    xa = {16{8'h7F}}; wa = {4{8'h7F}}; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a();
    repeat (10) @(negedge clk);

    // Reset in MAC aborts with cleared output and no done.
    issue_a(8'd32, 8'hC0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_y", ya, 32'h0);
    check("abort_busy", {31'b0, busy_a}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Reset and start together: reset wins.
    xa = {16{8'd32}}; wa = {4{8'd64}}; rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    check("rst_start_busy", {31'b0, busy_a}, 32'h0);
    repeat (10) @(negedge clk);
    check("rst_start_y", ya, 32'h0);

    // Wider build: LANES=2 over 5 columns.
    for (int j = 0; j < 5; j++) begin
      bw[j] = 8'(-64 - j * j);
      for (int i = 0; i < 3; i++) bx[j][i] = 8'(-64 - i * j);
    end
    issue_b(bx, bw, 24'h7F7F7F); wait_done_b(); @(negedge clk);

    for (int j = 0; j < 5; j++) begin
      bw[j] = 8'(16 * j - 30);
      for (int i = 0; i < 3; i++) bx[j][i] = 8'(i * 8 + j * 4 - 20);
    end
    issue_b(bx, bw, model_b(bx, bw)); wait_done_b(); @(negedge clk);

    for (int j = 0; j < 5; j++) begin
      bw[j] = 8'(j * 3 + 1);
      for (int i = 0; i < 3; i++) bx[j][i] = 8'((i + 1) * (j + 1) - 9);
    end
    issue_b(bx, bw, model_b(bx, bw)); wait_done_b();
    repeat (5) @(negedge clk);

    check("a_queue_drained", exp_a.size(), 32'h0);
    check("b_queue_drained", exp_b.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
